// File: rtl/rf_pkg.sv
// Shared types and helpers for the integer register file slice.
package rf_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rfState_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with flush/set/clear priority and per-port hazard view.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]  rd_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            flush
);

  logic [NREGS-1:0] busy;
  logic             wrHit;
  logic             issHit;

  // Operations only count once the sweep is done; address 0 never tracks a producer.
  assign wrHit  = run & wr_en  & (wr_addr  != '0);
  assign issHit = run & iss_en & (iss_addr != '0);

  // Flush beats everything; set is applied after clear so a same-address issue wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (run) begin
      if (flush) begin
        busy <= '0;
      end else begin
        if (wrHit)  busy[wr_addr]  <= 1'b0;
        if (issHit) busy[iss_addr] <= 1'b1;
      end
    end
  end

  // A writeback landing this cycle satisfies the reader via the bypass.
  for (genvar k = 0; k < NRD; k++) begin : gPort
    logic [AW-1:0] a;
    assign a          = rd_addr[k*AW +: AW];
    assign rd_busy[k] = busy[a] & ~(wrHit & (wr_addr == a));
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NRD combinational reads with write bypass, one write
// port, RAM-friendly storage cleared by a post-reset sweep, busy scoreboard.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rfState_e        state;
  logic [AW-1:0]   cnt;
  logic            run;
  logic            wrHit;
  logic [XLEN-1:0] mem [NREGS];

  assign run   = (state == RF_RUN);
  assign ready = run;
  assign wrHit = run & wr_en & (wr_addr != '0);

  // Sweep FSM: walk every entry once after reset, then park in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        RF_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= RF_RUN;
        end
        default: state <= RF_RUN;
      endcase
    end
  end

  // Storage has no reset so it maps onto RAM; the sweep supplies the clear.
  always_ff @(posedge clk) begin
    if (!run)       mem[cnt]     <= '0;
    else if (wrHit) mem[wr_addr] <= wr_data;
  end

  // Reads: zero while sweeping or for x0, bypass a same-cycle writeback.
  for (genvar k = 0; k < NRD; k++) begin : gRd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    assign rd_data[k*XLEN +: XLEN] =
      (!run || a == '0)          ? '0 :
      (wrHit && wr_addr == a)    ? wr_data :
                                   mem[a];
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) uSb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance (32x32, 2 ports) and a
// 16x64 instance with 3 read ports sharing clock and reset.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Instance A: defaults
  logic        aReady;
  logic [9:0]  aRdAddr;
  logic [63:0] aRdData;
  logic [1:0]  aRdBusy;
  logic        aWrEn, aIssEn, aFlush;
  logic [4:0]  aWrAddr, aIssAddr;
  logic [31:0] aWrData;

  // Instance B: NREGS=16, NRD=3, XLEN=64
  logic         bReady;
  logic [11:0]  bRdAddr;
  logic [191:0] bRdData;
  logic [2:0]   bRdBusy;
  logic         bWrEn, bIssEn, bFlush;
  logic [3:0]   bWrAddr, bIssAddr;
  logic [63:0]  bWrData;

  regfile_sb dutA (
    .clk(clk), .rst(rst), .ready(aReady),
    .rd_addr(aRdAddr), .rd_data(aRdData), .rd_busy(aRdBusy),
    .wr_en(aWrEn), .wr_addr(aWrAddr), .wr_data(aWrData),
    .iss_en(aIssEn), .iss_addr(aIssAddr), .flush(aFlush)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dutB (
    .clk(clk), .rst(rst), .ready(bReady),
    .rd_addr(bRdAddr), .rd_data(bRdData), .rd_busy(bRdBusy),
    .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData),
    .iss_en(bIssEn), .iss_addr(bIssAddr), .flush(bFlush)
  );

  task automatic idleA();
    aWrEn = 0; aWrAddr = 0; aWrData = 0; aIssEn = 0; aIssAddr = 0; aFlush = 0;
  endtask

  task automatic idleB();
    bWrEn = 0; bWrAddr = 0; bWrData = 0; bIssEn = 0; bIssAddr = 0; bFlush = 0;
  endtask

  // Count sweep edges after release; A ready after 32, B after 16.
  task automatic sweep(input string tag, input bit chkData);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (aReady !== (i == 32)) begin
        errs++; $display("FAIL %s A ready edge %0d: got %b expected %b", tag, i, aReady, (i == 32));
      end
      vecs++;
      if (bReady !== (i >= 16)) begin
        errs++; $display("FAIL %s B ready edge %0d: got %b expected %b", tag, i, bReady, (i >= 16));
      end
      if (chkData && i < 32) begin
        vecs++;
        if (aRdData !== 64'h0 || aRdBusy !== 2'b00) begin
          errs++; $display("FAIL %s sweep read edge %0d: got %h/%b expected 0/00", tag, i, aRdData, aRdBusy);
        end
      end
    end
  endtask

  task automatic test_reset();
    idleA(); idleB();
    aRdAddr = {5'd5, 5'd6}; bRdAddr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (aReady !== 1'b0 || bReady !== 1'b0) begin
      errs++; $display("FAIL reset ready: got %b/%b expected 0/0", aReady, bReady);
    end
    @(negedge clk);
    rst = 1'b0;
    // Writes and issues during the sweep must be ignored, including the exit edge.
    aWrEn = 1; aWrAddr = 5'd5; aWrData = 32'hFFFF_FFFF;
    aIssEn = 1; aIssAddr = 5'd6;
    sweep("reset", 1'b1);
    @(negedge clk);
    idleA();
    aRdAddr = {5'd5, 5'd6};
    #1;
    vecs++;
    if (aRdData !== 64'h0) begin
      errs++; $display("FAIL reset x5/x6 data: got %h expected 0", aRdData);
    end
    vecs++;
    if (aRdBusy !== 2'b00) begin
      errs++; $display("FAIL reset busy x6: got %b expected 00", aRdBusy);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    aWrEn = 1; aWrAddr = 5'd7; aWrData = 32'hDEAD_BEEF;
    aRdAddr = {5'd0, 5'd7};
    #1;
    vecs++;
    if (aRdData[31:0] !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL bypass p0: got %h expected deadbeef", aRdData[31:0]);
    end
    @(negedge clk);
    idleA();
    aRdAddr = {5'd7, 5'd7};
    #1;
    vecs++;
    if (aRdData !== 64'hDEAD_BEEF_DEAD_BEEF) begin
      errs++; $display("FAIL array p0/p1 x7: got %h expected deadbeefdeadbeef", aRdData);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    aWrEn = 1; aWrAddr = 5'd0; aWrData = 32'h1234_5678;
    aIssEn = 1; aIssAddr = 5'd0;
    aRdAddr = {5'd0, 5'd0};
    #1;
    vecs++;
    if (aRdData !== 64'h0 || aRdBusy !== 2'b00) begin
      errs++; $display("FAIL x0 same-cycle: got %h/%b expected 0/00", aRdData, aRdBusy);
    end
    @(negedge clk);
    idleA();
    #1;
    vecs++;
    if (aRdData !== 64'h0 || aRdBusy !== 2'b00) begin
      errs++; $display("FAIL x0 after edge: got %h/%b expected 0/00", aRdData, aRdBusy);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    aIssEn = 1; aIssAddr = 5'd3;
    aRdAddr = {5'd0, 5'd3};
    #1;
    vecs++;
    if (aRdBusy[0] !== 1'b0) begin
      errs++; $display("FAIL sb pre-issue x3: got %b expected 0", aRdBusy[0]);
    end
    @(negedge clk);
    idleA();
    #1;
    vecs++;
    if (aRdBusy[0] !== 1'b1) begin
      errs++; $display("FAIL sb issued x3: got %b expected 1", aRdBusy[0]);
    end
    aWrEn = 1; aWrAddr = 5'd3; aWrData = 32'h42;
    #1;
    vecs++;
    if (aRdBusy[0] !== 1'b0 || aRdData[31:0] !== 32'h42) begin
      errs++; $display("FAIL sb wb x3: got %b/%h expected 0/00000042", aRdBusy[0], aRdData[31:0]);
    end
    @(negedge clk);
    idleA();
    #1;
    vecs++;
    if (aRdBusy[0] !== 1'b0 || aRdData[31:0] !== 32'h42) begin
      errs++; $display("FAIL sb released x3: got %b/%h expected 0/00000042", aRdBusy[0], aRdData[31:0]);
    end
    // Set and clear on the same edge: set wins.
    aIssEn = 1; aIssAddr = 5'd3; aWrEn = 1; aWrAddr = 5'd3; aWrData = 32'h55;
    @(negedge clk);
    idleA();
    #1;
    vecs++;
    if (aRdBusy[0] !== 1'b1 || aRdData[31:0] !== 32'h55) begin
      errs++; $display("FAIL sb set-wins x3: got %b/%h expected 1/00000055", aRdBusy[0], aRdData[31:0]);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); aIssEn = 1; aIssAddr = 5'd1;
    @(negedge clk); aIssAddr = 5'd2;
    @(negedge clk); aIssAddr = 5'd9;
    @(negedge clk); idleA();
    aRdAddr = {5'd9, 5'd1};
    #1;
    vecs++;
    if (aRdBusy !== 2'b11) begin
      errs++; $display("FAIL flush pre x1/x9: got %b expected 11", aRdBusy);
    end
    aFlush = 1; aIssEn = 1; aIssAddr = 5'd4;
    @(negedge clk);
    idleA();
    #1;
    vecs++;
    if (aRdBusy !== 2'b00) begin
      errs++; $display("FAIL flush x1/x9: got %b expected 00", aRdBusy);
    end
    aRdAddr = {5'd4, 5'd2};
    #1;
    vecs++;
    if (aRdBusy !== 2'b00) begin
      errs++; $display("FAIL flush x2/x4: got %b expected 00", aRdBusy);
    end
    aRdAddr = {5'd0, 5'd3};
    #1;
    vecs++;
    if (aRdBusy !== 2'b00) begin
      errs++; $display("FAIL flush x3: got %b expected 00", aRdBusy);
    end
  endtask

  task automatic test_paramB();
    @(negedge clk); bWrEn = 1; bWrAddr = 4'd3;  bWrData = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); bWrAddr = 4'd10; bWrData = 64'hFEDC_BA98_7654_3210;
    @(negedge clk); bWrAddr = 4'd15; bWrData = 64'hA5A5_5A5A_C3C3_3C3C;
    @(negedge clk); idleB();
    bRdAddr = {4'd10, 4'd3, 4'd15};
    #1;
    vecs++;
    if (bRdData !== {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 64'hA5A5_5A5A_C3C3_3C3C}) begin
      errs++; $display("FAIL B three ports: got %h", bRdData);
    end
    bRdAddr = {4'd3, 4'd3, 4'd3};
    #1;
    vecs++;
    if (bRdData !== {3{64'h0123_4567_89AB_CDEF}}) begin
      errs++; $display("FAIL B same addr: got %h expected 3x0123456789abcdef", bRdData);
    end
    // Bypass on port 2 only, busy on port 1 only.
    bIssEn = 1; bIssAddr = 4'd10;
    @(negedge clk);
    idleB();
    bWrEn = 1; bWrAddr = 4'd5; bWrData = 64'h1111_2222_3333_4444;
    bRdAddr = {4'd5, 4'd10, 4'd0};
    #1;
    vecs++;
    if (bRdData !== {64'h1111_2222_3333_4444, 64'hFEDC_BA98_7654_3210, 64'h0}) begin
      errs++; $display("FAIL B bypass p2: got %h", bRdData);
    end
    vecs++;
    if (bRdBusy !== 3'b010) begin
      errs++; $display("FAIL B busy: got %b expected 010", bRdBusy);
    end
    @(negedge clk);
    idleB();
  endtask

  task automatic test_midreset();
    // Reset from RUN: ready and busy drop at once.
    @(negedge clk);
    aIssEn = 1; aIssAddr = 5'd5;
    @(negedge clk);
    idleA();
    aRdAddr = {5'd0, 5'd5};
    #1;
    vecs++;
    if (aRdBusy[0] !== 1'b1) begin
      errs++; $display("FAIL midreset pre busy x5: got %b expected 1", aRdBusy[0]);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (aReady !== 1'b0 || aRdBusy !== 2'b00) begin
      errs++; $display("FAIL midreset from RUN: got %b/%b expected 0/00", aReady, aRdBusy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    // Sweep is at entry 10 now; abort it.
    @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if (aReady !== 1'b0) begin
      errs++; $display("FAIL midreset in sweep: got %b expected 0", aReady);
    end
    @(negedge clk);
    rst = 1'b0;
    aRdAddr = {5'd3, 5'd7};
    sweep("midreset", 1'b1);
    @(negedge clk);
    #1;
    vecs++;
    if (aRdData !== 64'h0 || aRdBusy !== 2'b00) begin
      errs++; $display("FAIL midreset cleared x3/x7: got %h/%b expected 0/00", aRdData, aRdBusy);
    end
  endtask

  initial begin
    rst = 1'b1;
    idleA(); idleB();
    aRdAddr = '0; bRdAddr = '0;
    test_reset();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_flush();
    test_paramB();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
